// File: rtl/phase_ctrl_pkg.sv
// Shared types and encodings for the phase round controller.
// The sequencer phase encodings document the odd/even sequencer interface.
package phase_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ctrl_state_t;

    typedef logic [1:0] phase_t;

    localparam phase_t PH_FIRST  = 2'b11;
    localparam phase_t PH_SECOND = 2'b01;
    localparam phase_t PH_THIRD  = 2'b10;

endpackage

// File: rtl/phase_round_counter.sv
// Saturating round counter with synchronous clear, increment and a
// compare-to-target hit flag evaluated on the value the increment produces.
module phase_round_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic [CNT_W-1:0] target,
    output logic [CNT_W-1:0] count,
    output logic             hit
);

    logic [CNT_W-1:0] count_inc;

    // Hold at all-ones instead of wrapping.
    assign count_inc = (&count) ? count : count + 1'b1;
    assign hit       = inc & (count_inc == target);

    // Count register: clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count_inc;
        end
    end

endmodule

// File: rtl/phase_round_ctrl.sv
// Runs the 3-phase sequencer for a programmed number of rounds, steering its
// pause/restart inputs and counting terminal pulses.
// Optional watchdog enabled by defining PHASE_WDOG_EN.
//
//   state | meaning
//   IDLE  | sequencer parked in FIRST, waiting for start_i
//   RUN   | sequencer free-running, terminal pulses counted
//   DONE  | single-cycle completion, done_o high
module phase_round_ctrl
    import phase_ctrl_pkg::*;
#(
    parameter int CNT_W = 8
`ifdef PHASE_WDOG_EN
    ,
    parameter int WDOG_CYCLES = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [CNT_W-1:0] round_count_i,
    input  logic             stall_i,
    input  logic             abort_i,
    input  logic             terminal_i,
    output logic             pause_o,
    output logic             restart_o,
    output logic             ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] rounds_done_o,
    output logic             err_o
);

    ctrl_state_t      state;
    logic [CNT_W-1:0] target;
    logic             accept;
    logic             cnt_inc;
    logic             cnt_hit;
    logic             wdog_trip;

    // Outside RUN the sequencer is both paused and held in restart, which
    // parks it in FIRST; reset forces IDLE so both rise asynchronously.
    assign pause_o   = (state != RUN) | stall_i;
    assign restart_o = (state != RUN) | abort_i;
    assign ready_o   = (state == IDLE);
    assign busy_o    = (state == RUN);

    assign accept  = (state == IDLE) & start_i;
    // A terminal in the abort cycle comes from the restart itself.
    assign cnt_inc = (state == RUN) & terminal_i & ~abort_i;

    phase_round_counter #(
        .CNT_W (CNT_W)
    ) u_round_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (accept),
        .inc    (cnt_inc),
        .target (target),
        .count  (rounds_done_o),
        .hit    (cnt_hit)
    );

    // Control FSM with registered done pulse aligned to the DONE state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            target <= '0;
            done_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        if (round_count_i != '0) begin
                            target <= round_count_i;
                            state  <= RUN;
                        end else begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (abort_i) begin
                        state <= IDLE;
                    end else if (cnt_hit) begin
                        state  <= DONE;
                        done_o <= 1'b1;
                    end else if (wdog_trip) begin
                        state <= IDLE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef PHASE_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

    logic [WDOG_W-1:0] wdog_cnt;
    logic              err_q;

    // Trip on the RUN cycle that would bring the idle count to WDOG_CYCLES.
    assign wdog_trip = (state == RUN) & ~terminal_i & ~stall_i
                     & (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));
    assign err_o     = err_q;

    // Cycles spent in RUN without progress; stalls are host-intended waits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt <= '0;
        end else if ((state != RUN) | terminal_i | stall_i) begin
            wdog_cnt <= '0;
        end else begin
            wdog_cnt <= wdog_cnt + 1'b1;
        end
    end

    // Sticky error, cleared only by the next accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= 1'b0;
        end else if (wdog_trip & ~abort_i) begin
            err_q <= 1'b1;
        end
    end
`else
    assign wdog_trip = 1'b0;
    assign err_o     = 1'b0;
`endif

endmodule
